// File: rtl/encode_sequencer.sv
// ============================================================================
// encode_sequencer: sequences one sample encode into the window mapper.
// Optional macro SEQ_PERF_CNT_EN adds the stall_cnt_o performance counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module encode_sequencer #(
  parameter int MAX_WINDOW1_SIZE = 12,
  parameter int CNT_W            = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] sample_len_i,
  input  logic [5:0]       window_size_i,
  input  logic             sliding_mode_i,
  input  logic             sig_mode_i,
  input  logic [5:0]       shift_amount_i,
  input  logic             sym_valid_i,
  input  logic [5:0]       sym_data_i,
  output logic             sym_ready_o,
  input  logic             map_ready_i,
  output logic             map_in_valid_o,
  output logic [5:0]       map_in_value_o,
  output logic             map_soft_reset_no,
  output logic [5:0]       map_window_size_o,
  output logic             map_sliding_mode_o,
  output logic             map_sig_mode_o,
  output logic [5:0]       map_shift_amount_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] sym_count_o,
`ifdef SEQ_PERF_CNT_EN
  output logic [31:0]      stall_cnt_o,
`endif
  output logic             cfg_err_o
);

  localparam logic [5:0] MAX_WIN = 6'(MAX_WINDOW1_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] sample_len;
  logic             first;
  logic             guard;
  logic             issue;
  logic             drain_exit;
  logic [CNT_W-1:0] count_next;

  // guard masks the mapper ready for one cycle after a strobe, since the
  // mapper has not yet had time to drop it.
  assign issue      = (state == FEED) && sym_valid_i && (first || (map_ready_i && !guard));
  assign drain_exit = (state == DRAIN) && map_ready_i && !guard;
  assign count_next = sym_count_o + {{(CNT_W-1){1'b0}}, 1'b1};
  assign sym_ready_o = issue;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state              <= IDLE;
      sample_len         <= '0;
      first              <= 1'b0;
      guard              <= 1'b0;
      map_in_valid_o     <= 1'b0;
      map_in_value_o     <= '0;
      map_soft_reset_no  <= 1'b1;
      map_window_size_o  <= '0;
      map_sliding_mode_o <= 1'b0;
      map_sig_mode_o     <= 1'b0;
      map_shift_amount_o <= '0;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
      sym_count_o        <= '0;
      cfg_err_o          <= 1'b0;
    end else begin
      map_in_valid_o <= issue;
      guard          <= issue;
      done_o         <= 1'b0;
      if (issue) map_in_value_o <= sym_data_i;
      case (state)
        IDLE: begin
          if (start_i) begin
            sample_len         <= sample_len_i;
            map_sliding_mode_o <= sliding_mode_i;
            map_sig_mode_o     <= sig_mode_i;
            map_shift_amount_o <= shift_amount_i;
            if (window_size_i > MAX_WIN) begin
              map_window_size_o <= MAX_WIN;
              cfg_err_o         <= 1'b1;
            end else begin
              map_window_size_o <= window_size_i;
              cfg_err_o         <= 1'b0;
            end
            sym_count_o       <= '0;
            busy_o            <= 1'b1;
            map_soft_reset_no <= 1'b0;
            state             <= CLEAR;
          end
        end
        CLEAR: begin
          map_soft_reset_no <= 1'b1;
          first             <= 1'b1;
          if (sample_len == '0) begin
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            state <= FEED;
          end
        end
        FEED: begin
          if (issue) begin
            sym_count_o <= count_next;
            first       <= 1'b0;
            if (count_next == sample_len) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Mapper ready with guard clear means the last batch has finished.
          if (drain_exit) begin
            done_o <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic stall;
  assign stall = ((state == FEED) && !issue) || ((state == DRAIN) && !drain_exit);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if ((state == IDLE) && start_i) begin
      stall_cnt_o <= '0;
    end else if (stall && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_encode_sequencer.sv
// ============================================================================
// tb_encode_sequencer: self-checking bench for encode_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_encode_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic [5:0]  win;
  logic        sliding;
  logic        sig;
  logic [5:0]  shift;
  logic        sym_valid;
  logic [5:0]  sym_data;
  logic        sym_ready;
  logic        map_ready;
  logic        map_in_valid;
  logic [5:0]  map_in_value;
  logic        map_srn;
  logic [5:0]  map_win;
  logic        map_sl;
  logic        map_sig;
  logic [5:0]  map_shift;
  logic        busy;
  logic        done;
  logic [15:0] sym_count;
  logic        cfg_err;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  encode_sequencer #(.MAX_WINDOW1_SIZE(12), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sample_len_i(len),
    .window_size_i(win), .sliding_mode_i(sliding), .sig_mode_i(sig),
    .shift_amount_i(shift), .sym_valid_i(sym_valid), .sym_data_i(sym_data),
    .sym_ready_o(sym_ready), .map_ready_i(map_ready),
    .map_in_valid_o(map_in_valid), .map_in_value_o(map_in_value),
    .map_soft_reset_no(map_srn), .map_window_size_o(map_win),
    .map_sliding_mode_o(map_sl), .map_sig_mode_o(map_sig),
    .map_shift_amount_o(map_shift), .busy_o(busy), .done_o(done),
    .sym_count_o(sym_count),
`ifdef SEQ_PERF_CNT_EN
    .stall_cnt_o(stall_cnt),
`endif
    .cfg_err_o(cfg_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Upstream symbol source and mapper emulation
  int      q[$];
  bit      src_en   = 1'b0;
  bit      auto_rdy = 1'b0;
  int      rdy_cnt  = 0;

  initial begin
    bit took;
    forever begin
      @(posedge clk);
      took = sym_valid && sym_ready && !rst;
      @(negedge clk);
      #2;
      if (took && q.size() > 0) void'(q.pop_front());
      sym_valid = src_en && (q.size() > 0);
      if (q.size() > 0) sym_data = 6'(q[0]);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (auto_rdy) begin
        if (map_in_valid) begin
          map_ready = 1'b0;
          rdy_cnt   = 2;
        end else if (rdy_cnt > 0) begin
          rdy_cnt--;
          if (rdy_cnt == 0) map_ready = 1'b1;
        end
      end
    end
  end

  // Reference model: sample-level phases advanced on each clock edge
  int          cyc = 0;
  int          ph;
  int          start_cyc;
  logic        m_first, m_guard, m_busy, m_done, m_srn, m_strobe, m_err, m_sl, m_sig;
  logic [5:0]  m_value, m_win, m_shift;
  int          m_len, m_count;
  logic        exp_ready, act_ready;

  initial begin
    bit iss, dex;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        ph = 0; m_first = 0; m_guard = 0; m_busy = 0; m_done = 0; m_srn = 1;
        m_strobe = 0; m_err = 0; m_sl = 0; m_sig = 0; m_value = 0; m_win = 0;
        m_shift = 0; m_len = 0; m_count = 0; exp_ready = 0; act_ready = 0;
      end else begin
        iss = (ph == 2) && sym_valid && (m_first || (map_ready && !m_guard));
        dex = (ph == 3) && map_ready && !m_guard;
        exp_ready = iss;
        act_ready = sym_ready;
        m_strobe  = iss;
        if (iss) m_value = sym_data;
        m_done = 0;
        case (ph)
          0: if (start) begin
               m_len = int'(len); m_sl = sliding; m_sig = sig; m_shift = shift;
               m_win = (win > 6'd11) ? 6'd11 : win;
               m_err = (win > 6'd11);
               m_count = 0; m_busy = 1; m_srn = 0; ph = 1; start_cyc = cyc;
             end
          1: begin
               m_srn = 1; m_first = 1;
               if (m_len == 0) begin ph = 4; m_done = 1; end
               else ph = 2;
             end
          2: if (iss) begin
               m_count++; m_first = 0;
               if (m_count == m_len) ph = 3;
             end
          3: if (dex) begin ph = 4; m_done = 1; end
          default: begin m_busy = 0; ph = 0; end
        endcase
        m_guard = iss;
      end
    end
  end

  // Monitor statistics
  int strobes, done_cnt, srn_low, ready_cnt, min_gap, last_e, first_e;
  int vals[$];

  task automatic reset_stats();
    strobes = 0; done_cnt = 0; srn_low = 0; ready_cnt = 0;
    min_gap = 1000; last_e = -1; first_e = -1; vals.delete();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (map_in_valid) begin
          strobes++;
          vals.push_back(int'(map_in_value));
          if (last_e >= 0 && cyc - last_e < min_gap) min_gap = cyc - last_e;
          if (first_e < 0) first_e = cyc;
          last_e = cyc;
        end
        if (done) done_cnt++;
        if (!map_srn) srn_low++;
        if (act_ready) ready_cnt++;
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("strobe", map_in_valid, m_strobe);
        chk("value", map_in_value, m_value);
        chk("soft_reset_n", map_srn, m_srn);
        chk("sym_count", sym_count, m_count);
        chk("cfg_err", cfg_err, m_err);
        chk("window", map_win, m_win);
        chk("sliding", map_sl, m_sl);
        chk("sig", map_sig, m_sig);
        chk("shift", map_shift, m_shift);
        chk("sym_ready", act_ready, exp_ready);
      end
      cyc++;
    end
  end

  task automatic run_start(input int l, input int w, input bit sl, input bit sg, input int sh);
    @(negedge clk);
    start = 1'b1; len = 16'(l); win = 6'(w); sliding = sl; sig = sg; shift = 6'(sh);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int i = 0;
    while (done_cnt == 0 && i < 300) begin @(negedge clk); i++; end
    if (done_cnt == 0) begin
      n_checks++; n_err++;
      $display("FAIL %s_timeout: got no done expected done within 300 cycles", name);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_strobes(input int n, input string name);
    int i = 0;
    while (strobes < n && i < 300) begin @(negedge clk); i++; end
    if (strobes < n) begin
      n_checks++; n_err++;
      $display("FAIL %s_timeout: got %0d strobes expected %0d", name, strobes, n);
    end
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_srn"}, map_srn, 1);
    chk({tag, "_count"}, sym_count, 0);
    chk({tag, "_strobe"}, map_in_valid, 0);
    chk({tag, "_window"}, map_win, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, cfg_err, 0);
    chk({tag, "_ready"}, sym_ready, 0);
  endtask

  initial begin
    int snap;
    rst = 1'b1; start = 0; len = 0; win = 0; sliding = 0; sig = 0; shift = 0;
    sym_valid = 0; sym_data = 0; map_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset_literals("reset");
    rst = 1'b0;
    reset_stats();

    // Basic sliding sample
    auto_rdy = 1'b1; src_en = 1'b1;
    q = '{5, 9, 2, 7};
    run_start(4, 3, 1, 0, 0);
    wait_done("basic");
    chk("basic_strobes", strobes, 4);
    for (int i = 0; i < 4; i++) chk("basic_val", (i < vals.size()) ? vals[i] : -1, (i == 0) ? 5 : (i == 1) ? 9 : (i == 2) ? 2 : 7);
    chk("basic_count", sym_count, 4);
    chk("basic_done_pulses", done_cnt, 1);
    chk("basic_latency", first_e - start_cyc + 1, 3);

    // Zero length
    reset_stats();
    q = '{33};
    run_start(0, 3, 1, 0, 0);
    wait_done("zero");
    chk("zero_strobes", strobes, 0);
    chk("zero_ready", ready_cnt, 0);
    chk("zero_srn_low", srn_low, 1);
    chk("zero_done", done_cnt, 1);
    q.delete();
    repeat (2) @(negedge clk);

    // Window clamp then clear
    reset_stats();
    q = '{1};
    run_start(1, 15, 0, 1, 6);
    wait_done("clamp");
    chk("clamp_window", map_win, 11);
    chk("clamp_err", cfg_err, 1);
    chk("clamp_shift", map_shift, 6);
    reset_stats();
    q = '{2};
    run_start(1, 4, 0, 0, 0);
    wait_done("unclamp");
    chk("unclamp_err", cfg_err, 0);
    chk("unclamp_window", map_win, 4);

    // Back-to-back guard with ready tied high
    auto_rdy = 1'b0; map_ready = 1'b1;
    reset_stats();
    q = '{3, 4, 6};
    run_start(3, 5, 1, 0, 0);
    wait_done("guard");
    chk("guard_strobes", strobes, 3);
    chk("guard_min_gap_ge2", min_gap >= 2, 1);
    chk("guard_last_val", (vals.size() == 3) ? vals[2] : -1, 6);
    auto_rdy = 1'b1;

    // Upstream stall with an ignored start
    reset_stats();
    q = '{10, 11, 12, 13, 14};
    run_start(5, 3, 1, 0, 0);
    wait_strobes(2, "stall");
    src_en = 1'b0;
    snap = strobes;
    repeat (3) @(negedge clk);
    run_start(9, 7, 0, 1, 2);
    repeat (6) @(negedge clk);
    chk("stall_no_strobes", strobes, snap);
    chk("stall_window_kept", map_win, 3);
    chk("stall_busy", busy, 1);
    src_en = 1'b1;
    wait_done("stall");
    chk("stall_strobes", strobes, 5);
    chk("stall_count", sym_count, 5);
    chk("stall_last_val", (vals.size() == 5) ? vals[4] : -1, 14);

    // Reset mid-sample, then a full sample
    reset_stats();
    q = '{20, 21, 22, 23, 24};
    run_start(5, 3, 1, 0, 0);
    wait_strobes(2, "midrst");
    @(negedge clk);
    #3 rst = 1'b1;
    #1 reset_literals("midrst");
    @(negedge clk);
    rst = 1'b0;
    q = '{30, 31, 32, 33, 34};
    reset_stats();
    run_start(5, 3, 1, 0, 0);
    wait_done("after_rst");
    chk("after_rst_strobes", strobes, 5);
    chk("after_rst_count", sym_count, 5);
    chk("after_rst_first", (vals.size() > 0) ? vals[0] : -1, 30);
    chk("after_rst_last", (vals.size() == 5) ? vals[4] : -1, 34);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
